// File: rtl/instr_fetch_unit_pkg.sv
// Shared types for the fetch stage and the pipeline registers that follow it.
package instr_fetch_unit_pkg;

  typedef logic [31:0] pc_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef struct packed {
    logic [31:0] instr;
    pc_t         pc;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc: '0, valid: 1'b0};

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: control from later stages, imem address/data, IF/ID outputs.
interface instr_fetch_unit_if #(
  parameter int CNT_W = 16
) ();
  import instr_fetch_unit_pkg::*;

  logic             STALL;
  logic             REDIRECT_EN;
  pc_t              REDIRECT_PC;
  pc_t              ADDRESS;
  logic [31:0]      INSTRUCTION;
  logic [31:0]      IFID_INSTR;
  pc_t              IFID_PC;
  logic             IFID_VALID;
  logic             DONE;
  logic [CNT_W-1:0] FETCH_COUNT;

  modport master (
    output STALL, REDIRECT_EN, REDIRECT_PC, INSTRUCTION,
    input  ADDRESS, IFID_INSTR, IFID_PC, IFID_VALID, DONE, FETCH_COUNT
  );

  modport slave (
    input  STALL, REDIRECT_EN, REDIRECT_PC, INSTRUCTION,
    output ADDRESS, IFID_INSTR, IFID_PC, IFID_VALID, DONE, FETCH_COUNT
  );
endinterface

// File: rtl/instr_fetch_unit_ifid_reg.sv
// Generic pipeline register for ifid_t: bubble beats load, otherwise hold.
module instr_fetch_unit_ifid_reg
  import instr_fetch_unit_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load_i,
  input  logic  bubble_i,
  input  ifid_t d_i,
  output ifid_t q_o
);

  ifid_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (bubble_i)    q_d = IFID_BUBBLE;
    else if (load_i) q_d = d_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= IFID_BUBBLE;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives imem address from a flop, loads IF/ID,
// stops at PC_LIMIT and counts fetched instructions (saturating).
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter pc_t RESET_PC = 32'd0,
  parameter pc_t PC_LIMIT = 32'd9,
  parameter int  CNT_W    = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  instr_fetch_unit_if.slave  bus
);

  localparam logic [0:0] S_FETCH   = 1'b0;
  localparam logic [0:0] S_STOPPED = 1'b1;
  localparam logic [0:0] S_RESET   = (RESET_PC >= PC_LIMIT) ? S_STOPPED : S_FETCH;

  pc_t              pc_q, pc_d;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ifid_load, ifid_bubble;
  ifid_t            ifid_d, ifid_q;
  pc_t              pc_inc;

  assign pc_inc = pc_q + 32'd1;  // wraps naturally at 2^32
  assign ifid_d = '{instr: bus.INSTRUCTION, pc: pc_q, valid: 1'b1};

  always_comb begin
    pc_d        = pc_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    if (bus.REDIRECT_EN) begin
      // Redirect overrides stall: the squashed path must never reach decode.
      pc_d        = bus.REDIRECT_PC;
      ifid_bubble = 1'b1;
      state_d     = (bus.REDIRECT_PC >= PC_LIMIT) ? S_STOPPED : S_FETCH;
    end else if (bus.STALL) begin
      // everything holds
    end else if (state_q == S_STOPPED) begin
      ifid_bubble = 1'b1;
    end else begin
      ifid_load = 1'b1;
      pc_d      = pc_inc;
      state_d   = (pc_inc >= PC_LIMIT) ? S_STOPPED : S_FETCH;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q    <= RESET_PC;
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  instr_fetch_unit_ifid_reg u_ifid (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .d_i      (ifid_d),
    .q_o      (ifid_q)
  );

  assign bus.ADDRESS     = pc_q;
  assign bus.IFID_INSTR  = ifid_q.instr;
  assign bus.IFID_PC     = ifid_q.pc;
  assign bus.IFID_VALID  = ifid_q.valid;
  assign bus.DONE        = (state_q == S_STOPPED);
  assign bus.FETCH_COUNT = cnt_q;

endmodule
